ifu_fetch_buffer: RTL and testbench

IFU_FETCH_BUFFER -- requirements
Module: ifu_fetch_buffer

---
 rtl/ifu_fetch_buffer.sv | 117 +++++++++++
 tb/tb_ifu_fetch_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_buffer.sv
// Instruction fetch buffer: issues one imem request at a time and queues {pc, inst} pairs for IF/ID.
// Optional macro IFB_BYPASS_EN forwards a response straight to the output when the queue is empty.
module ifu_fetch_buffer #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic [1:0]  dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // Handshakes: imem transfers a request on imem_req & imem_gnt, a response on imem_rvalid
    // (always accepted); the output side transfers on out_valid & out_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    logic [63:0]   fetch_pc;
    logic [63:0]   req_pc;
    logic [63:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic grant;
    logic push;
    logic pop;
    logic bypass;

`ifdef IFB_BYPASS_EN
    assign bypass = ~rst & ~redirect_valid & (state == WAIT) & imem_rvalid & out_ready
                    & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    // Requests only from IDLE with a free slot, so a granted response always has room.
    assign imem_req  = ~rst & ~redirect_valid & (state == IDLE) & (count < FULL_COUNT);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;

    assign push      = ~rst & ~redirect_valid & (state == WAIT) & imem_rvalid & ~bypass;
    assign out_valid = ~rst & ~redirect_valid & ((count != '0) | bypass);
    assign out_pc    = bypass ? req_pc : pc_mem[rd_ptr];
    assign out_inst  = bypass ? imem_rdata : inst_mem[rd_ptr];
    assign pop       = out_valid & out_ready & ~bypass;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (redirect_valid) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= {redirect_pc[63:2], 2'b00};
            // An in-flight request must still be answered before fetching again.
            if (state == IDLE || imem_rvalid) begin
                state <= IDLE;
            end else begin
                state <= DROP;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 64'd4;
                        state    <= WAIT;
                    end
                end
                WAIT: if (imem_rvalid) state <= IDLE;
                DROP: if (imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= req_pc;
            inst_mem[wr_ptr] <= imem_rdata;
        end
    end

    push_never_full: assert property (@(posedge clk) disable iff (rst) push |-> (count != FULL_COUNT));

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// Randomized bench for ifu_fetch_buffer: a transaction-level model predicts fetch addresses,
// handshakes and the ordered instruction stream; a monitor compares against it every cycle.
module tb_ifu_fetch_buffer;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          DEPTH    = 4;
`ifdef IFB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  dbg_state;

    ifu_fetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and reference model state
    logic [95:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          m_out  = 1'b0;   // a fetch is outstanding at the memory
    bit          m_drop = 1'b0;   // the outstanding fetch was cancelled by a redirect
    logic [63:0] m_pc   = RESET_PC;
    logic [63:0] m_pend_pc = RESET_PC;
    bit          e_req, e_byp;
    bit          g_flag = 1'b0;
    logic [63:0] g_addr;
    bit          pend = 1'b0;
    int          dly  = 0;
    logic [63:0] paddr;

    function automatic logic [31:0] mix(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5a3c_96e1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        if ($urandom_range(9, 0) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0;
        else t = 64'h8000_0000 + 64'($urandom_range(1023, 0)) * 64'd4;
        return t | 64'($urandom_range(3, 0));
    endfunction

    // driver: one call drives the inputs of one cycle, memory answers grants after a delay
    task automatic drive_cycle(input int gnt_pct, input int ready_pct, input int redir_pct,
                               input int min_dly, input int max_dly, input bit do_rst,
                               input bit frc_redir, input logic [63:0] frc_pc);
        @(posedge clk);
        #1;
        if (rst || imem_rvalid) pend = 1'b0;
        if (g_flag) begin
            pend  = 1'b1;
            paddr = g_addr;
            dly   = $urandom_range(max_dly, min_dly);
        end
        rst      = do_rst;
        imem_gnt = ($urandom_range(99, 0) < gnt_pct);
        if (pend && dly == 0 && !do_rst) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mix(paddr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend && dly != 0) dly--;
        end
        out_ready = ($urandom_range(99, 0) < ready_pct);
        if (frc_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = frc_pc;
        end else begin
            redirect_valid = ($urandom_range(99, 0) < redir_pct);
            redirect_pc    = rand_target();
        end
    endtask

    // monitor: compares DUT outputs with the model and pops delivered instructions
    initial begin
        logic [95:0] e;
        logic [1:0]  e_state;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_req = !rst && !redirect_valid && !m_out && (exp_q.size() < DEPTH);
            e_byp = BYP && !rst && !redirect_valid && m_out && !m_drop && imem_rvalid
                    && out_ready && (exp_q.size() == 0);
            e_state = m_out ? (m_drop ? 2'd2 : 2'd1) : 2'd0;
            check("imem_req", 64'(imem_req), 64'(e_req));
            check("out_valid", 64'(out_valid),
                  64'(!rst && !redirect_valid && (exp_q.size() != 0 || e_byp)));
            check("state", 64'(dbg_state), 64'(e_state));
            if (e_req && imem_gnt) check("imem_addr", imem_addr, m_pc);
            if (out_valid && out_ready) begin
                if (e_byp) begin
                    check("byp_pc", out_pc, m_pend_pc);
                    check("byp_inst", 64'(out_inst), 64'(mix(m_pend_pc)));
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e[95:32]);
                    check("out_inst", 64'(out_inst), 64'(e[31:0]));
                end
            end
        end
    end

    // reference model: applies the fetch rules for the coming clock edge
    initial begin
        forever begin
            @(negedge clk);
            #1;
            g_flag = 1'b0;
            if (imem_req && imem_gnt) begin
                g_flag = 1'b1;
                g_addr = imem_addr;
            end
            if (rst) begin
                exp_q.delete();
                m_out  = 1'b0;
                m_drop = 1'b0;
                m_pc   = RESET_PC;
            end else if (redirect_valid) begin
                exp_q.delete();
                m_pc = {redirect_pc[63:2], 2'b00};
                if (m_out) begin
                    if (imem_rvalid) begin
                        m_out  = 1'b0;
                        m_drop = 1'b0;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
            end else begin
                if (m_out && imem_rvalid) begin
                    if (!m_drop && !e_byp) exp_q.push_back({m_pend_pc, mix(m_pend_pc)});
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end
                if (e_req && imem_gnt) begin
                    m_out     = 1'b1;
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 64'd4;
                end
            end
        end
    end

    // stimulus sequence
    initial begin
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        repeat (3) drive_cycle(100, 100, 0, 0, 0, 1'b1, 1'b0, '0);

        // streaming with single-cycle memory and an always-ready consumer
        repeat (30) drive_cycle(100, 100, 0, 0, 0, 1'b0, 1'b0, '0);

        // back-pressure fills the queue, then drains in order
        repeat (20) drive_cycle(100, 0, 0, 0, 0, 1'b0, 1'b0, '0);
        repeat (20) drive_cycle(100, 100, 0, 0, 0, 1'b0, 1'b0, '0);

        // redirect in WAIT with a late response
        for (int i = 0; i < 20 && !(m_out && !m_drop); i++)
            drive_cycle(100, 100, 0, 3, 3, 1'b0, 1'b0, '0);
        drive_cycle(100, 100, 0, 3, 3, 1'b0, 1'b1, 64'h8000_1002);
        repeat (12) drive_cycle(100, 100, 0, 0, 0, 1'b0, 1'b0, '0);

        // redirect coincident with the response that would fill the queue
        for (int i = 0; i < 40 && !(imem_req && imem_gnt && exp_q.size() == DEPTH - 1); i++)
            drive_cycle(100, 0, 0, 0, 0, 1'b0, 1'b0, '0);
        drive_cycle(100, 0, 0, 0, 0, 1'b0, 1'b1, 64'h8000_2000);
        repeat (12) drive_cycle(100, 100, 0, 0, 0, 1'b0, 1'b0, '0);

        // 64-bit wrap of the fetch address
        drive_cycle(100, 100, 0, 0, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        repeat (10) drive_cycle(100, 100, 0, 0, 0, 1'b0, 1'b0, '0);

        // reset pulsed while a fetch is outstanding
        for (int i = 0; i < 20 && !m_out; i++)
            drive_cycle(100, 100, 0, 2, 2, 1'b0, 1'b0, '0);
        drive_cycle(100, 100, 0, 2, 2, 1'b1, 1'b0, '0);
        repeat (12) drive_cycle(100, 100, 0, 0, 0, 1'b0, 1'b0, '0);

        // random traffic with redirects, stalls, variable latency and rare resets
        for (int i = 0; i < 4000; i++)
            drive_cycle(70, 60, 5, 0, 3, ($urandom_range(199, 0) == 0), 1'b0, '0);
        repeat (20) drive_cycle(100, 100, 0, 0, 0, 1'b0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
